// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_if.sv
// Start/busy/done handshake and operand/result bus between the execute stage and the MDU.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu_step.sv
// One combinational iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    // Partial remainder shifted left with the next dividend bit; never exceeds 2*divisor-1.
    shifted = acc[2*WIDTH-1:WIDTH-1];
    trial   = shifted - {1'b0, opnd};
    acc_nxt = '0;
    if (div) begin
      if (!trial[WIDTH]) acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative 32-cycle multiply / restoring divide producing HI/LO behind a start/busy/done handshake.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU finish at once leaving HI/LO untouched.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

`ifdef MDU_DIV_EN
  localparam bit DIV_HW = 1'b1;
`else
  localparam bit DIV_HW = 1'b0;
`endif

  state_e             state, state_nxt;
  logic [5:0]         cnt;
  logic               busy_r, done_r, dbz_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd, a_raw;
  logic               div_r, sa_r, sb_r, zdiv_r;

  md_op_e             op_in;
  logic               accept, div_in, sgn_in;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_dbz;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign op_in  = md_op_e'(bus.op);
  assign div_in = (op_in == MD_DIV) || (op_in == MD_DIVU);
  assign sgn_in = (op_in == MD_MULT) || (op_in == MD_DIV);
  assign accept = (state == IDLE) && bus.start;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div     (div_r & DIV_HW),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (div_in && (!DIV_HW || bus.b == '0)) ? FIN : RUN;
      RUN:  if (cnt == 6'd1) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign fix-up applied on the way into HI/LO; magnitudes come straight from the core.
  always_comb begin
    prod    = cneg2(acc, sa_r ^ sb_r);
    res_hi  = hi_r;
    res_lo  = lo_r;
    res_dbz = 1'b0;
    if (!div_r) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (DIV_HW) begin
      if (zdiv_r) begin
        res_hi  = a_raw;
        res_lo  = '1;
        res_dbz = 1'b1;
      end else begin
        res_hi = cneg(acc[2*WIDTH-1:WIDTH], sa_r);
        res_lo = cneg(acc[WIDTH-1:0], sa_r ^ sb_r);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      state  <= state_nxt;
      busy_r <= (state_nxt != IDLE);
      done_r <= (state == FIN);
      dbz_r  <= (state == FIN) && res_dbz;
      if (accept)              cnt <= 6'(MDU_ITERS);
      else if (state == RUN)   cnt <= cnt - 6'd1;
      if (state == FIN) begin
        hi_r <= res_hi;
        lo_r <= res_lo;
      end
    end
  end

  // Operand capture on the accepted start, then one iteration per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_raw  <= bus.a;
      div_r  <= div_in;
      sa_r   <= sgn_in & bus.a[WIDTH-1];
      sb_r   <= sgn_in & bus.b[WIDTH-1];
      zdiv_r <= (bus.b == '0);
      opnd   <= cneg(bus.b, sgn_in & bus.b[WIDTH-1]);
      acc    <= {{WIDTH{1'b0}}, cneg(bus.a, sgn_in & bus.a[WIDTH-1])};
    end else if (state == RUN) begin
      acc <= acc_nxt;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed, handshake, reset and randomized ops against an arithmetic model.
module tb_mdu;
  import mdu_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam int NDIR = 8;
  localparam logic [1:0]  DOP [NDIR] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd0};
  localparam logic [31:0] DA  [NDIR] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h123F00AB,
                                         32'h80000000, 32'h80000005, 32'h00000007, 32'h80000000};
  localparam logic [31:0] DB  [NDIR] = '{32'hFFFFFFFF, 32'h00000003, 32'h00000002, 32'h00000000,
                                         32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE, 32'h80000000};

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_if #(.WIDTH(32)) bus ();
  mdu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference: results from plain 64-bit arithmetic, latency from the op class.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] h, output logic [31:0] l, output logic z);
    longint  ps;
    logic [63:0] pu;
    int sa, sb;
    h = m_hi; l = m_lo; z = 1'b0; lat = 33;
    if (op == 2'd0) begin
      ps = longint'($signed(a)) * longint'($signed(b));
      {h, l} = ps;
    end else if (op == 2'd1) begin
      pu = {32'd0, a} * {32'd0, b};
      {h, l} = pu;
    end else if (!DIV_EN) begin
      lat = 1;
    end else if (b == 32'd0) begin
      lat = 1; h = a; l = 32'hFFFFFFFF; z = 1'b1;
    end else if (op == 2'd2) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        l = 32'h80000000; h = 32'd0;
      end else begin
        sa = $signed(a); sb = $signed(b);
        l = sa / sb; h = sa % sb;
      end
    end else begin
      l = a / b; h = a % b;
    end
    m_hi = h; m_lo = l;
  endtask

  // Polls negedges starting at cycle index n0 until done; n = -1 on timeout.
  task automatic wait_done(input int n0, output int n, output bit busy_bad);
    busy_bad = 1'b0; n = -1;
    for (int k = n0; k < n0 + 60; k++) begin
      @(negedge clk);
      if (bus.done) begin
        n = k;
        if (bus.busy) busy_bad = 1'b1;
        break;
      end
      if (!bus.busy) busy_bad = 1'b1;
    end
  endtask

  // Presents start for one edge (E0), then scrambles the inputs to prove they were captured.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n, output bit bb);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
    wait_done(0, n, bb);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int n, elat; bit bb; logic [31:0] eh, el; logic ez;
    for (int i = 0; i < NDIR; i++) begin
      model_op(DOP[i], DA[i], DB[i], elat, eh, el, ez);
      do_op(DOP[i], DA[i], DB[i], n, bb);
      checks++; if (n !== elat) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, n, elat); end
      checks++; if (bb) begin errors++; $display("FAIL dir%0d_busy got dropped-early-or-late want high-until-done", i); end
      checks++; if (bus.hi !== eh) begin errors++; $display("FAIL dir%0d_hi got %h want %h", i, bus.hi, eh); end
      checks++; if (bus.lo !== el) begin errors++; $display("FAIL dir%0d_lo got %h want %h", i, bus.lo, el); end
      checks++; if (bus.div_by_zero !== ez) begin errors++; $display("FAIL dir%0d_dbz got %b want %b", i, bus.div_by_zero, ez); end
    end
  endtask

  task automatic test_handshake();
    int n, elat; bit bb; logic [31:0] eh, el, ra, rb; logic ez;
    model_op(2'd1, 32'h4C5A6789, 32'd2, elat, eh, el, ez);
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'h4C5A6789; bus.b = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'd0; bus.a = $urandom; bus.b = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(10, n, bb);
    checks++; if (n !== elat) begin errors++; $display("FAIL hs_latency got %0d want %0d", n, elat); end
    checks++; if (bb) begin errors++; $display("FAIL hs_busy got dropped-early-or-late want high-until-done"); end
    checks++; if (bus.hi !== eh) begin errors++; $display("FAIL hs_hi got %h want %h", bus.hi, eh); end
    checks++; if (bus.lo !== el) begin errors++; $display("FAIL hs_lo got %h want %h", bus.lo, el); end
    ra = $urandom; rb = $urandom;
    model_op(2'd0, ra, rb, elat, eh, el, ez);
    do_op(2'd0, ra, rb, n, bb);
    checks++; if (n !== elat) begin errors++; $display("FAIL b2b_latency got %0d want %0d", n, elat); end
    checks++; if (bus.hi !== eh) begin errors++; $display("FAIL b2b_hi got %h want %h", bus.hi, eh); end
    checks++; if (bus.lo !== el) begin errors++; $display("FAIL b2b_lo got %h want %h", bus.lo, el); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", bus.done); end
    checks++; if (bus.lo !== el) begin errors++; $display("FAIL hold_lo got %h want %h", bus.lo, el); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [1:0] op;
    op = DIV_EN ? 2'd3 : 2'd1;
    bus.start = 1'b1; bus.op = op; bus.a = $urandom | 32'h1; bus.b = $urandom_range(1, 1000);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", bus.done); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rmid_hi got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL rmid_lo got %h want 0", bus.lo); end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rmid_quiet got activity want none"); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int n, elat; bit bb; logic [31:0] eh, el, ra, rb; logic ez; logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = pick(); rb = pick();
      model_op(op, ra, rb, elat, eh, el, ez);
      do_op(op, ra, rb, n, bb);
      checks++; if (n !== elat) begin errors++; $display("FAIL rnd%0d_latency op%0d got %0d want %0d", i, op, n, elat); end
      checks++; if (bb) begin errors++; $display("FAIL rnd%0d_busy got dropped-early-or-late want high-until-done", i); end
      checks++; if (bus.hi !== eh) begin errors++; $display("FAIL rnd%0d_hi op%0d a=%h b=%h got %h want %h", i, op, ra, rb, bus.hi, eh); end
      checks++; if (bus.lo !== el) begin errors++; $display("FAIL rnd%0d_lo op%0d a=%h b=%h got %h want %h", i, op, ra, rb, bus.lo, el); end
      checks++; if (bus.div_by_zero !== ez) begin errors++; $display("FAIL rnd%0d_dbz got %b want %b", i, bus.div_by_zero, ez); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the single-cycle CPU's execute stage. It sits beside the ALU, takes the same register-file operands A and B, and produces the HI/LO results consumed by MFHI/MFLO write-back. It runs a 32-iteration shift-add multiply and a 32-iteration restoring divide behind a start/busy/done handshake. The control unit stalls the PC while `busy` is high.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.

- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: request; sampled only when not busy.
- `op`, in, 2: operation. 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a`, in, WIDTH: multiplicand / dividend.
- `b`, in, WIDTH: multiplier / divisor.
- `busy`, out, 1: operation in flight.
- `done`, out, 1: one-cycle pulse; `hi`/`lo` are valid from this cycle onward.
- `hi`, out, WIDTH: product[63:32] or remainder.
- `lo`, out, WIDTH: product[31:0] or quotient.
- `div_by_zero`, out, 1: pulses together with `done` when a divide had `b` = 0.

## Operation
- **FSM states and transitions:**
  - IDLE → RUN on `start`.
  - IDLE → FIN on `start` with a divide op and `b` = 0.
  - RUN → FIN when the iteration counter reaches 0.
  - FIN → IDLE unconditionally.
- **Operand capture on an accepted start:**
  - `op`, `a` and `b` are captured on the accepted-start edge.
  - Later changes on `a`, `b` and `op` are ignored.
- **Signed ops:**
  - The core iterates on absolute values. |0x80000000| = 0x80000000, treated as unsigned.
  - FIN applies the sign fix:
    - The product is negated (64-bit) when the operand signs differ.
    - The quotient is negated when the operand signs differ.
    - The remainder takes the dividend's sign.
- **Multiply:** 64-bit accumulator, one conditional add-and-shift per RUN cycle, 32 iterations.
- **Divide:** restoring divide, one shift-and-trial-subtract per RUN cycle, 32 iterations.
- **Divide by zero:** `hi` = `a`, `lo` = 0xFFFFFFFF, `div_by_zero` = 1.
- **DIV overflow** (0x80000000 / 0xFFFFFFFF): `lo` = 0x80000000, `hi` = 0. No flag is raised.
- **Result hold:** `hi`/`lo` update only in FIN and hold until the next FIN or reset.
- **Start while busy:** ignored and not queued.

## Timing
- **Reset values:** `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, state IDLE.
- **Reset mid-operation:** aborts immediately and clears all outputs to their reset values.
- **Normal operation** (start accepted at edge E0):
  - `busy` is high after E0 through E33.
  - Iterations occur at E1..E32.
  - `hi`/`lo` are written and `done` is high in the cycle after E33.
  - `busy` is low in that same cycle.
- **Divide by zero:** FIN occurs at E1, and `done`/`div_by_zero` are high in the cycle after E1.
- **Back-to-back operations:**
  - `start` is accepted in the same cycle that `done` is high, since the FSM is then in IDLE.
  - No bubble is required.
- **`busy`** is a registered output; it is never combinationally derived from `start`.

## Configuration
- **With `MDU_DIV_EN` defined:** divide hardware is present and all four ops behave as specified above.
- **Without `MDU_DIV_EN`:**
  - A DIV or DIVU start goes directly to FIN, so `done` is high in the cycle after E1.
  - `hi`/`lo` are left unchanged and `div_by_zero` = 0.
  - MULT/MULTU behaviour is unchanged.

## Structure
- **Package `mdu_pkg`:**
  - `op` encoding enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - FSM state enum (IDLE, RUN, FIN).
  - Constants: `MDU_WIDTH` = 32 and `MDU_ITERS` = 32.
- **Sub-module `mdu_step`:**
  - Combinational single iteration: conditional add + shift for multiply, trial subtract + shift for divide.
  - Instantiated once.
  - FSM, counter, sign handling and the HI/LO registers stay in `mdu`.

## Test plan
- **MULTU:** `a` = 0xFFFFFFFF, `b` = 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001; `done` high in the cycle after E33.
- **MULT:** `a` = 0xFFFFFFFE, `b` = 0x00000003 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA.
- **DIV:** `a` = 0xFFFFFFF9, `b` = 0x00000002 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- **DIVU:** `a` = 0x123F00AB, `b` = 0 → `done` and `div_by_zero` high in the cycle after E1, `hi` = 0x123F00AB, `lo` = 0xFFFFFFFF.
- **Handshake:**
  - MULTU 0x4C5A6789 × 2 is started.
  - A second `start` at E10 with different operands is ignored: result `lo` = 0x98B4CF12, `hi` = 0.
  - A new `start` issued while `done` is high is accepted.
- **Reset mid-operation:** `reset` pulsed at E15 of a DIVU → `busy`/`done` go to 0 and `hi`/`lo` to 0 asynchronously, with no `done` pulse afterwards.
